// File: rtl/lif_rnn_layer_pkg.sv
// lif_pkg: shared definitions for the LIF recurrent spiking layer.
//   lif_state_e      - layer sequencer state encoding
//   RESET_MODE_*     - post-spike potential handling selectors
//   SAT_MIN/sat_max  - saturation bounds for the membrane potential
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } lif_state_e;

    localparam int RESET_MODE_SUB  = 0;
    localparam int RESET_MODE_ZERO = 1;

    localparam int SAT_MIN = 0;

    // Upper saturation bound for an unsigned potential of the given width.
    function automatic int sat_max(input int state_w);
        return (1 << state_w) - 1;
    endfunction

endpackage

// File: rtl/lif_rnn_layer_if.sv
// lif_rnn_layer_if: timestep input/output handshake bundle of the layer.
//   in_valid/in_ready/in_data : one timestep of input currents
//   clear                     : zero potentials and previous spikes (IDLE only)
//   out_valid/out_ready       : completed timestep result handshake
//   spikes                    : spike vector of the last completed timestep
//   step_count                : completed timesteps, modulo 2^16
// master = producer/consumer side, slave = the layer.
interface lif_rnn_layer_if #(
    parameter int N_NEURONS = 4,
    parameter int IN_W      = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [N_NEURONS*IN_W-1:0]   in_data;
    logic                        clear;
    logic                        out_valid;
    logic                        out_ready;
    logic [N_NEURONS-1:0]        spikes;
    logic [15:0]                 step_count;

    modport master (
        output in_valid, in_data, clear, out_ready,
        input  in_ready, out_valid, spikes, step_count
    );

    modport slave (
        input  in_valid, in_data, clear, out_ready,
        output in_ready, out_valid, spikes, step_count
    );
endinterface

// File: rtl/lif_rnn_layer_neuron_update.sv
// lif_neuron_update: combinational single-neuron leaky integrate-and-fire step.
//   i_v        - current membrane potential
//   i_in       - input current for this neuron
//   i_prev_spk - previous-step spike of the recurrent neighbour
//   o_v        - next membrane potential
//   o_spk      - neuron fires this step
module lif_neuron_update
    import lif_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int STATE_W     = 10,
    parameter int THRESHOLD   = 200,
    parameter int DECAY_SHIFT = 1,
    parameter int REC_W       = 16,
    parameter int RESET_MODE  = 0
) (
    input  logic [STATE_W-1:0] i_v,
    input  logic [IN_W-1:0]    i_in,
    input  logic               i_prev_spk,
    output logic [STATE_W-1:0] o_v,
    output logic               o_spk
);

    // Two guard bits: one for the sign of a negative recurrent weight,
    // one for headroom above the saturation bound.
    localparam int SUM_W = STATE_W + 2;

    localparam logic signed [SUM_W-1:0]   SAT_HI   = SUM_W'(sat_max(STATE_W));
    localparam logic signed [SUM_W-1:0]   SAT_LO   = SUM_W'(SAT_MIN);
    localparam logic signed [SUM_W-1:0]   REC_TERM = SUM_W'(REC_W);
    localparam logic        [STATE_W-1:0] THRESH   = STATE_W'(THRESHOLD);

    logic signed [SUM_W-1:0]   w_v_ext;
    logic signed [SUM_W-1:0]   w_leak;
    logic signed [SUM_W-1:0]   w_in_ext;
    logic signed [SUM_W-1:0]   w_rec;
    logic signed [SUM_W-1:0]   w_sum;
    logic        [STATE_W-1:0] w_sat;

    assign w_v_ext  = {2'b00, i_v};
    assign w_leak   = {2'b00, i_v >> DECAY_SHIFT};
    assign w_in_ext = SUM_W'(i_in);
    assign w_rec    = i_prev_spk ? REC_TERM : '0;
    assign w_sum    = w_v_ext - w_leak + w_in_ext + w_rec;

    always_comb begin
        w_sat = '0;
        o_v   = '0;
        o_spk = 1'b0;

        if (w_sum < SAT_LO) begin
            w_sat = '0;
        end else if (w_sum > SAT_HI) begin
            w_sat = SAT_HI[STATE_W-1:0];
        end else begin
            w_sat = w_sum[STATE_W-1:0];
        end

        if (w_sat >= THRESH) begin
            o_spk = 1'b1;
            o_v   = (RESET_MODE == RESET_MODE_SUB) ? (w_sat - THRESH) : '0;
        end else begin
            o_v   = w_sat;
        end
    end

endmodule

// File: rtl/lif_rnn_layer.sv
// lif_rnn_layer: layer of N_NEURONS LIF neurons with a ring recurrence
// (neuron i sees the previous-step spike of neuron i-1). One neuron is
// updated per cycle through a shared lif_neuron_update datapath.
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset
//   io_bus - timestep handshake bundle (slave side)
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | ready for a timestep; honours clear
// ST_UPDATE | updating neuron r_idx, 0..N_NEURONS-1, one per cycle
// ST_DONE   | result valid, held until out_ready
module lif_rnn_layer
    import lif_pkg::*;
#(
    parameter int N_NEURONS   = 4,
    parameter int IN_W        = 8,
    parameter int STATE_W     = 10,
    parameter int THRESHOLD   = 200,
    parameter int DECAY_SHIFT = 1,
    parameter int REC_W       = 16,
    parameter int RESET_MODE  = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    lif_rnn_layer_if.slave io_bus
);

    localparam int               IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    lif_state_e                r_state;
    lif_state_e                w_state_nxt;
    logic [IDX_W-1:0]          r_idx;
    logic [N_NEURONS*IN_W-1:0] r_in_data;
    logic [STATE_W-1:0]        r_v [N_NEURONS];
    logic [N_NEURONS-1:0]      r_prev_spk;
    logic [N_NEURONS-1:0]      r_new_spk;
    logic [N_NEURONS-1:0]      r_spikes;
    logic [15:0]               r_step_count;

    logic                      w_in_ready;
    logic                      w_out_valid;
    logic                      w_clear;
    logic                      w_last;
    logic [IDX_W-1:0]          w_prev_idx;
    logic [IN_W-1:0]           w_in_cur;
    logic [STATE_W-1:0]        w_v_cur;
    logic [STATE_W-1:0]        w_v_nxt;
    logic                      w_rec_spk;
    logic                      w_spk;
    logic [N_NEURONS-1:0]      w_new_spk;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (io_bus.in_valid) begin
                    w_state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (io_bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_clear    = (r_state == ST_IDLE) && io_bus.clear;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_prev_idx = (r_idx == '0) ? LAST_IDX : (r_idx - 1'b1);
    assign w_in_cur   = r_in_data[r_idx*IN_W +: IN_W];
    assign w_v_cur    = r_v[r_idx];
    // Recurrence reads last step's spikes only; r_prev_spk is not touched
    // until the whole step has completed.
    assign w_rec_spk  = r_prev_spk[w_prev_idx];

    always_comb begin
        w_new_spk        = r_new_spk;
        w_new_spk[r_idx] = w_spk;
    end

    lif_neuron_update #(
        .IN_W        (IN_W),
        .STATE_W     (STATE_W),
        .THRESHOLD   (THRESHOLD),
        .DECAY_SHIFT (DECAY_SHIFT),
        .REC_W       (REC_W),
        .RESET_MODE  (RESET_MODE)
    ) u_neuron (
        .i_v        (w_v_cur),
        .i_in       (w_in_cur),
        .i_prev_spk (w_rec_spk),
        .o_v        (w_v_nxt),
        .o_spk      (w_spk)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_in_data    <= '0;
            r_prev_spk   <= '0;
            r_new_spk    <= '0;
            r_spikes     <= '0;
            r_step_count <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    // Clear and capture share an edge, so a step accepted
                    // together with clear starts from zero potentials.
                    if (w_clear) begin
                        r_prev_spk <= '0;
                        for (int i = 0; i < N_NEURONS; i++) begin
                            r_v[i] <= '0;
                        end
                    end
                    if (io_bus.in_valid) begin
                        r_in_data <= io_bus.in_data;
                        r_idx     <= '0;
                        r_new_spk <= '0;
                    end
                end
                ST_UPDATE: begin
                    r_v[r_idx] <= w_v_nxt;
                    r_new_spk  <= w_new_spk;
                    if (w_last) begin
                        r_spikes     <= w_new_spk;
                        r_prev_spk   <= w_new_spk;
                        r_step_count <= r_step_count + 16'd1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.in_ready   = w_in_ready;
    assign io_bus.out_valid  = w_out_valid;
    assign io_bus.spikes     = r_spikes;
    assign io_bus.step_count = r_step_count;

endmodule

// File: tb/tb_lif_rnn_layer.sv
// tb_lif_rnn_layer: directed and randomized checks of lif_rnn_layer against
// an arithmetic reference model of the LIF recurrence.
`timescale 1ns/1ps
module tb_lif_rnn_layer;

    localparam int N           = 4;
    localparam int IN_W        = 8;
    localparam int STATE_W     = 10;
    localparam int THRESHOLD   = 200;
    localparam int DECAY_SHIFT = 1;
    localparam int REC_W       = 16;
    localparam int RESET_MODE  = 0;
    localparam int DW          = N * IN_W;
    localparam int VMAX        = (1 << STATE_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lif_rnn_layer_if #(.N_NEURONS(N), .IN_W(IN_W)) bus ();

    lif_rnn_layer #(
        .N_NEURONS   (N),
        .IN_W        (IN_W),
        .STATE_W     (STATE_W),
        .THRESHOLD   (THRESHOLD),
        .DECAY_SHIFT (DECAY_SHIFT),
        .REC_W       (REC_W),
        .RESET_MODE  (RESET_MODE)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int           checks = 0;
    int           errors = 0;
    int           v_m [N];
    logic [N-1:0] prev_m;
    logic [N-1:0] spk_m;
    int           count_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) v_m[i] = 0;
        prev_m  = '0;
        spk_m   = '0;
        count_m = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) v_m[i] = 0;
        prev_m = '0;
    endtask

    task automatic model_step(input logic [DW-1:0] d, input bit clr);
        logic [N-1:0] fired;
        int s;
        if (clr) model_clear();
        fired = '0;
        for (int i = 0; i < N; i++) begin
            s = v_m[i] - (v_m[i] >> DECAY_SHIFT) + int'(d[i*IN_W +: IN_W]);
            if (prev_m[(i + N - 1) % N]) s = s + REC_W;
            if (s < 0) s = 0;
            if (s > VMAX) s = VMAX;
            if (s >= THRESHOLD) begin
                fired[i] = 1'b1;
                v_m[i]   = (RESET_MODE == 0) ? s - THRESHOLD : 0;
            end else begin
                v_m[i] = s;
            end
        end
        prev_m  = fired;
        spk_m   = fired;
        count_m = (count_m + 1) % 65536;
    endtask

    task automatic check_potentials(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s%0d", tag, i), 32'(dut.r_v[i]), 32'(v_m[i]));
        end
    endtask

    // One timestep from IDLE; optionally holds DONE for 'hold' cycles while
    // poking in_valid/clear, which must be ignored there.
    task automatic run_step(input logic [DW-1:0] d, input bit clr, input int hold, input bit poke);
        int lat;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.clear    = clr;
        model_step(d, clr);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                bus.in_valid = 1'b0;
                bus.clear    = 1'b0;
            end
        end while (!bus.out_valid && lat < 40);
        check("latency", 32'(lat), 32'(N + 1));
        check("spikes", 32'(bus.spikes), 32'(spk_m));
        check("step_count", 32'(bus.step_count), 32'(count_m));
        check_potentials("v");
        for (int k = 0; k < hold; k++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.clear    = 1'b1;
                bus.in_data  = ~d;
            end
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_spikes", 32'(bus.spikes), 32'(spk_m));
        end
        bus.in_valid  = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("ret_out_valid", 32'(bus.out_valid), 32'd0);
        check("ret_in_ready", 32'(bus.in_ready), 32'd1);
        if (poke) begin
            @(posedge clk);
            @(negedge clk);
            check("poke_no_step", 32'(bus.out_valid), 32'd0);
            check("poke_count", 32'(bus.step_count), 32'(count_m));
            check_potentials("v_poke");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_spikes", 32'(bus.spikes), 32'd0);
        check("rst_step_count", 32'(bus.step_count), 32'd0);

        // Two steps of constant 150: 150 no spike, then 225 -> all fire, v=25
        d = {N{8'd150}};
        run_step(d, 1'b0, 0, 1'b0);
        check("c150_s1_spikes", 32'(bus.spikes), 32'd0);
        check("c150_s1_v0", 32'(dut.r_v[0]), 32'd150);
        run_step(d, 1'b0, 0, 1'b0);
        check("c150_s2_spikes", 32'(bus.spikes), 32'hF);
        check("c150_s2_v3", 32'(dut.r_v[3]), 32'd25);

        // Standalone clear, then recurrence from neuron 0 into neuron 1
        bus.clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.clear = 1'b0;
        model_clear();
        check_potentials("v_clr");
        check("clr_keeps_spikes", 32'(bus.spikes), 32'hF);
        d = '0;
        d[IN_W-1:0] = 8'd250;
        run_step(d, 1'b0, 0, 1'b0);
        check("rec_s1_spikes", 32'(bus.spikes), 32'b0001);
        check("rec_s1_v0", 32'(dut.r_v[0]), 32'd50);
        run_step('0, 1'b0, 0, 1'b0);
        check("rec_s2_v1", 32'(dut.r_v[1]), 32'd16);
        check("rec_s2_v0", 32'(dut.r_v[0]), 32'd25);
        check("rec_s2_spikes", 32'(bus.spikes), 32'd0);

        // Back-pressure in DONE with ignored in_valid/clear
        d = {8'd90, 8'd220, 8'd10, 8'd240};
        run_step(d, 1'b0, 6, 1'b1);

        // Reset during the second UPDATE cycle
        bus.in_data  = {N{8'd150}};
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_spikes", 32'(bus.spikes), 32'd0);
        check("midrst_count", 32'(bus.step_count), 32'd0);
        check_potentials("v_midrst");
        run_step({N{8'd150}}, 1'b0, 0, 1'b0);
        check("midrst_v0", 32'(dut.r_v[0]), 32'd150);
        check("midrst_nospike", 32'(bus.spikes), 32'd0);

        // step_count wrap: preload just below the top, run two steps
        force dut.r_step_count = 16'hFFFE;
        #1;
        release dut.r_step_count;
        count_m = 16'hFFFE;
        run_step({N{8'd150}}, 1'b0, 0, 1'b0);
        check("wrap_ffff", 32'(bus.step_count), 32'hFFFF);
        run_step({N{8'd150}}, 1'b0, 0, 1'b0);
        check("wrap_zero", 32'(bus.step_count), 32'd0);

        // Clear together with the handshake: step starts from zero
        run_step({N{8'd100}}, 1'b1, 0, 1'b0);
        check("clr_hs_v2", 32'(dut.r_v[2]), 32'd100);
        check("clr_hs_spikes", 32'(bus.spikes), 32'd0);

        // Randomized steps against the model
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < N; i++) begin
                d[i*IN_W +: IN_W] = IN_W'($urandom_range(0, 255));
            end
            run_step(d, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
